alu_exec_unit: RTL and testbench

Handshaked execute-stage ALU that consumes the 4-bit ALU operation code produced by the ALU control decoder, together with two 32-bit operands, and returns a registered result plus a zero flag for branch resolution. AND/OR/ADD/SUB complete in one cycle. MUL is an iterative shift-add operation taking 32 cycles. The block sits between the decode/ALU-control logic (upstream) and the memory/write-back stage (downstream) of the multi-cycle datapath.

---
 rtl/alu_exec_unit_if.sv | 26 ++
 rtl/alu_exec_unit.sv | 107 ++++++++++
 tb/tb_alu_exec_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_unit_if.sv
// Handshake bundle between the ALU-control/decode stage and the execute ALU.
// The upstream side (decode, or a bench) uses master; the ALU uses slave.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_ctrl;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, alu_ctrl, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_ctrl, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle AND/OR/ADD/SUB, 32-iteration shift-add MUL,
// with a one-entry registered output slot and a valid/ready handshake on both sides.
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_exec_unit_if.slave bus
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_MUL = 4'b0011,
        OP_SUB = 4'b0110
    } op_e;

    typedef enum logic {
        IDLE,
        MUL
    } state_e;

    state_e          state;
    logic [4:0]      count;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] acc_next;
    logic [XLEN-1:0] alu_res;
    logic            alu_illegal;
    logic            accept;
    logic            start_mul;

    // New work only when idle and the output slot is empty or draining this cycle.
    assign bus.in_ready = rst_n && (state == IDLE) && (!bus.out_valid || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign start_mul    = accept && (bus.alu_ctrl == OP_MUL);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        alu_res     = '0;
        alu_illegal = 1'b0;
        case (bus.alu_ctrl)
            OP_AND:  alu_res = bus.src_a & bus.src_b;
            OP_OR:   alu_res = bus.src_a | bus.src_b;
            OP_ADD:  alu_res = bus.src_a + bus.src_b;
            OP_SUB:  alu_res = bus.src_a - bus.src_b;
            OP_MUL:  alu_res = '0;
            default: alu_illegal = 1'b1;
        endcase
        acc_next = mplier[0] ? acc + mcand : acc;
    end

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.zero      <= 1'b0;
            bus.illegal   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_mul) begin
                        state         <= MUL;
                        count         <= '0;
                        bus.out_valid <= 1'b0;
                    end else if (accept) begin
                        bus.out_valid <= 1'b1;
                        bus.result    <= alu_res;
                        bus.zero      <= (alu_res == '0);
                        bus.illegal   <= alu_illegal;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state         <= IDLE;
                        bus.out_valid <= 1'b1;
                        bus.result    <= acc_next;
                        bus.zero      <= (acc_next == '0);
                        bus.illegal   <= 1'b0;
                    end
                end
            endcase
        end
    end

    // NOTE: multiplier datapath registers carry no reset; they are always loaded at MUL start before use.
    always_ff @(posedge clk) begin
        if (start_mul) begin
            mcand  <= bus.src_a;
            mplier <= bus.src_b;
            acc    <= '0;
        end else if (state == MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model (arithmetic result + countdown latency).
module tb_alu_exec_unit;

    localparam int XLEN = 32;
    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_MUL = 4'b0011;
    localparam logic [3:0] C_SUB = 4'b0110;

    logic clk = 1'b0;
    logic rst_n;

    alu_exec_unit_if #(.XLEN(XLEN)) bus ();

    alu_exec_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the output slot and the MUL cycles still to run.
    logic        m_ov       = 1'b0;
    logic [31:0] m_res      = '0;
    logic        m_zero     = 1'b0;
    logic        m_ill      = 1'b0;
    int          m_left     = 0;
    logic [31:0] m_prod     = '0;
    logic        m_accepted = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic is_legal(input logic [3:0] op);
        return (op == C_AND) || (op == C_OR) || (op == C_ADD) || (op == C_SUB) || (op == C_MUL);
    endfunction

    function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            C_AND:   return a & b;
            C_OR:    return a | b;
            C_ADD:   return a + b;
            C_SUB:   return a - b;
            C_MUL:   return a * b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic exp_ready();
        return rst_n && (m_left == 0) && (!m_ov || bus.out_ready);
    endfunction

    task automatic model_step();
        logic acc;
        acc = exp_ready() && bus.in_valid;
        m_accepted = acc;
        if (!rst_n) begin
            m_ov   = 1'b0;
            m_res  = '0;
            m_zero = 1'b0;
            m_ill  = 1'b0;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_ov   = 1'b1;
                m_res  = m_prod;
                m_zero = (m_prod == 0);
                m_ill  = 1'b0;
            end
        end else if (acc && bus.alu_ctrl == C_MUL) begin
            m_ov   = 1'b0;
            m_left = 32;
            m_prod = ref_op(C_MUL, bus.src_a, bus.src_b);
        end else if (acc) begin
            m_ov   = 1'b1;
            m_res  = ref_op(bus.alu_ctrl, bus.src_a, bus.src_b);
            m_zero = (m_res == 0);
            m_ill  = !is_legal(bus.alu_ctrl);
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Per-cycle comparison, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready()});
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, m_ov});
        if (m_ov) begin
            check("result", bus.result, m_res);
            check("zero", {31'b0, bus.zero}, {31'b0, m_zero});
            check("illegal", {31'b0, bus.illegal}, {31'b0, m_ill});
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic ordy);
        bus.in_valid  = v;
        bus.alu_ctrl  = op;
        bus.src_a     = a;
        bus.src_b     = b;
        bus.out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_mul(input string name, input logic [31:0] exp);
        int   n;
        logic ready_seen;
        n = 0;
        ready_seen = 1'b0;
        while (!bus.out_valid && n < 40) begin
            if (bus.in_ready) ready_seen = 1'b1;
            tick();
            n++;
        end
        check({name, " latency"}, n, 32);
        check({name, " busy in_ready"}, {31'b0, ready_seen}, 32'h0);
        check({name, " result"}, bus.result, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        logic [3:0] op;
        int r;

        // Model pins: hand-computed values.
        check("model and", ref_op(C_AND, 32'hF0F0F0F0, 32'hFF00FF00), 32'hF000F000);
        check("model sub", ref_op(C_SUB, 32'd5, 32'd7), 32'hFFFFFFFE);
        check("model mul", ref_op(C_MUL, 32'h00012345, 32'h00000100), 32'h01234500);
        check("model mul wrap", ref_op(C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'h00000001);
        check("model illegal", {31'b0, is_legal(4'hF)}, 32'h0);

        // Reset with in_valid asserted.
        rst_n = 1'b0;
        drive(1'b1, C_ADD, 32'd1, 32'd2, 1'b1);
        repeat (3) begin
            tick();
            check("reset in_ready", {31'b0, bus.in_ready}, 32'h0);
            check("reset out_valid", {31'b0, bus.out_valid}, 32'h0);
            check("reset result", bus.result, 32'h0);
        end
        rst_n = 1'b1;
        drive(1'b0, C_ADD, 32'd0, 32'd0, 1'b1);
        tick();
        check("idle in_ready", {31'b0, bus.in_ready}, 32'h1);

        // Back-to-back single-cycle ops.
        drive(1'b1, C_AND, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1); tick();
        check("and result", bus.result, 32'hF000F000);
        check("and valid", {31'b0, bus.out_valid}, 32'h1);
        drive(1'b1, C_OR, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1); tick();
        check("or result", bus.result, 32'hFFF0FFF0);
        drive(1'b1, C_ADD, 32'hFFFFFFFF, 32'd1, 1'b1); tick();
        check("add wrap result", bus.result, 32'h0);
        check("add wrap zero", {31'b0, bus.zero}, 32'h1);
        drive(1'b1, C_SUB, 32'd5, 32'd7, 1'b1); tick();
        check("sub result", bus.result, 32'hFFFFFFFE);
        check("sub zero", {31'b0, bus.zero}, 32'h0);
        drive(1'b0, C_ADD, 32'd0, 32'd0, 1'b1); tick();
        check("drain out_valid", {31'b0, bus.out_valid}, 32'h0);

        // MUL latency and results.
        drive(1'b1, C_MUL, 32'h00012345, 32'h00000100, 1'b1); tick();
        drive(1'b0, C_ADD, 32'd0, 32'd0, 1'b1);
        run_mul("mul1", 32'h01234500);
        drive(1'b1, C_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1); tick();
        check("mul retire out_valid", {31'b0, bus.out_valid}, 32'h0);
        drive(1'b0, C_ADD, 32'd0, 32'd0, 1'b1);
        run_mul("mul2", 32'h00000001);
        tick();

        // Backpressure then back-to-back replacement.
        drive(1'b1, C_ADD, 32'd3, 32'd4, 1'b0); tick();
        drive(1'b1, C_SUB, 32'd9, 32'd9, 1'b0);
        repeat (5) begin
            tick();
            check("bp result", bus.result, 32'd7);
            check("bp in_ready", {31'b0, bus.in_ready}, 32'h0);
            check("bp out_valid", {31'b0, bus.out_valid}, 32'h1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp ready rise", {31'b0, bus.in_ready}, 32'h1);
        tick();
        check("bp sub result", bus.result, 32'h0);
        check("bp sub zero", {31'b0, bus.zero}, 32'h1);
        check("bp sub valid", {31'b0, bus.out_valid}, 32'h1);
        drive(1'b0, C_ADD, 32'd0, 32'd0, 1'b1); tick();

        // Illegal op, then a legal op clears the flag.
        drive(1'b1, 4'hF, 32'h1234, 32'h5678, 1'b1); tick();
        check("illegal result", bus.result, 32'h0);
        check("illegal zero", {31'b0, bus.zero}, 32'h1);
        check("illegal flag", {31'b0, bus.illegal}, 32'h1);
        drive(1'b1, C_AND, 32'hF, 32'h3, 1'b1); tick();
        check("legal clears illegal", {31'b0, bus.illegal}, 32'h0);
        check("legal after illegal", bus.result, 32'h3);
        drive(1'b0, C_ADD, 32'd0, 32'd0, 1'b1); tick();

        // Reset during MUL iteration 10.
        drive(1'b1, C_MUL, 32'd7, 32'd9, 1'b1); tick();
        drive(1'b0, C_ADD, 32'd0, 32'd0, 1'b1);
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("post reset in_ready", {31'b0, bus.in_ready}, 32'h1);
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        check("aborted mul output", {31'b0, seen}, 32'h0);

        // Randomized traffic; upstream holds its inputs until accepted.
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            if (!bus.in_valid || m_accepted) begin
                r = $urandom_range(0, 19);
                if (r < 4)       op = C_AND;
                else if (r < 8)  op = C_OR;
                else if (r < 12) op = C_ADD;
                else if (r < 16) op = C_SUB;
                else if (r < 18) op = C_MUL;
                else             op = 4'($urandom_range(7, 15));
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.alu_ctrl = op;
                bus.src_a    = $urandom;
                case ($urandom_range(0, 3))
                    0:       bus.src_b = bus.src_a;
                    1:       bus.src_b = 32'($urandom_range(0, 15));
                    2:       bus.src_b = -bus.src_a;
                    default: bus.src_b = $urandom;
                endcase
            end
            tick();
        end

        rst_n = 1'b1;
        drive(1'b0, C_ADD, 32'd0, 32'd0, 1'b1);
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
